led_pwm_sequencer: RTL



---
 rtl/led_pwm_sequencer.sv | 119 +++++++++++
 1 files changed

// File: rtl/led_pwm_sequencer.sv
// led_pwm_sequencer: Avalon-MM LED bank driver that plays a programmable mask/duty step table via PWM
module led_pwm_sequencer #(
    parameter int PRESCALE_W     = 28,
    parameter int STEP_W         = 16,
    parameter int RESET_PRESCALE = 49999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  avs_address,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [7:0]  leds,
    output logic        irq
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t r_state, w_next;
    logic                  r_run, r_oneshot, r_irq_en, r_done, r_irq;
    logic [PRESCALE_W-1:0] r_prescale, r_pre_cnt;
    logic [STEP_W-1:0]     r_step_len, r_period_cnt, w_len;
    logic [STEP_W:0]       w_pnext;
    logic [2:0]            r_num_steps, r_pat_addr, r_step;
    logic [7:0]            r_pwm_cnt, r_leds, w_led;
    logic [7:0]            r_mask [8];
    logic [7:0]            r_duty [8];
    logic [31:0]           r_readdata, w_rd;
    logic w_ctrl_wr, w_start, w_stat_wr, w_pat_acc, w_tick, w_pend, w_plast, w_adv, w_slast, w_finish, w_clr, w_busy;
    logic w_unused;
    assign w_unused  = &{1'b0, avs_writedata};
    assign w_ctrl_wr = avs_write && avs_address == 3'd0;
    assign w_start   = w_ctrl_wr && avs_writedata[0];
    assign w_stat_wr = avs_write && avs_address == 3'd4;
    assign w_pat_acc = (avs_write || avs_read) && avs_address == 3'd6;
    assign w_busy    = r_state == S_RUN;
    assign w_tick    = w_busy && r_pre_cnt >= r_prescale;
    assign w_pend    = w_tick && r_pwm_cnt == 8'hFF;
    assign w_len     = (r_step_len == '0) ? STEP_W'(1) : r_step_len;
    assign w_pnext   = {1'b0, r_period_cnt} + (STEP_W+1)'(1);
    assign w_plast   = w_pnext >= {1'b0, w_len};
    assign w_adv     = w_pend && w_plast;
    assign w_slast   = r_step >= r_num_steps;
    assign w_finish  = w_adv && w_slast && r_oneshot;
    assign w_clr     = !w_busy || w_ctrl_wr;
    assign w_led     = r_mask[r_step] & {8{r_pwm_cnt < r_duty[r_step]}};
    assign avs_readdata = r_readdata;
    assign leds = r_leds;
    assign irq  = r_irq;
    // Next state: CTRL writes override everything, otherwise RUN ends only on a one-shot finish
    always_comb begin
        w_next = (w_busy && !w_ctrl_wr) ? (w_finish ? S_DONE : S_RUN) : (w_start ? S_RUN : S_IDLE);
    end
    // State register
    always_ff @(posedge clk) begin
        r_state <= reset ? S_IDLE : w_next;
    end
    // Prescaler, PWM, period and step counters; held at zero outside RUN and on any CTRL write
    always_ff @(posedge clk) begin
        if (reset || w_clr) begin
            r_pre_cnt    <= '0;
            r_pwm_cnt    <= '0;
            r_period_cnt <= '0;
            r_step       <= '0;
        end else begin
            r_pre_cnt <= w_tick ? '0 : r_pre_cnt + 1'b1;
            if (w_tick) r_pwm_cnt <= r_pwm_cnt + 1'b1;
            if (w_pend) r_period_cnt <= w_plast ? '0 : r_period_cnt + 1'b1;
            if (w_adv && !w_finish) r_step <= w_slast ? '0 : r_step + 1'b1;
        end
    end
    // Register file, pattern table, done/irq and LED output
    always_ff @(posedge clk) begin
        if (reset) begin
            {r_irq_en, r_oneshot, r_run} <= '0;
            r_prescale  <= PRESCALE_W'(RESET_PRESCALE);
            r_step_len  <= STEP_W'(1);
            r_num_steps <= '0;
            r_pat_addr  <= '0;
            r_done      <= 1'b0;
            r_irq       <= 1'b0;
            r_leds      <= '0;
            r_readdata  <= '0;
            for (int i = 0; i < 8; i++) begin
                r_mask[i] <= '0;
                r_duty[i] <= '0;
            end
        end else begin
            if (w_ctrl_wr) {r_irq_en, r_oneshot, r_run} <= {avs_writedata[3], avs_writedata[1], avs_writedata[0]};
            else if (r_state == S_DONE) r_run <= 1'b0;
            if (avs_write && avs_address == 3'd1) r_prescale <= avs_writedata[PRESCALE_W-1:0];
            if (avs_write && avs_address == 3'd2) r_step_len <= avs_writedata[STEP_W-1:0];
            if (avs_write && avs_address == 3'd3) r_num_steps <= avs_writedata[2:0];
            if (avs_write && avs_address == 3'd5) r_pat_addr <= avs_writedata[2:0];
            else if (w_pat_acc) r_pat_addr <= r_pat_addr + 1'b1;
            if (avs_write && avs_address == 3'd6) begin
                r_mask[r_pat_addr] <= avs_writedata[7:0];
                r_duty[r_pat_addr] <= avs_writedata[15:8];
            end
            r_done     <= (r_state == S_DONE) || (r_done && !(w_start || (w_stat_wr && avs_writedata[1])));
            r_irq      <= r_done && r_irq_en;
            r_leds     <= (w_busy && w_next == S_RUN) ? w_led : '0;
            r_readdata <= avs_read ? w_rd : '0;
        end
    end
    // Read data mux
    always_comb begin
        w_rd = '0;
        case (avs_address)
            3'd0: w_rd[3:0] = {r_irq_en, 1'b0, r_oneshot, r_run};
            3'd1: w_rd[PRESCALE_W-1:0] = r_prescale;
            3'd2: w_rd[STEP_W-1:0] = r_step_len;
            3'd3: w_rd[2:0] = r_num_steps;
            3'd4: w_rd[6:0] = {r_step, 2'b00, r_done, w_busy};
            3'd5: w_rd[2:0] = r_pat_addr;
            3'd6: w_rd[15:0] = {r_duty[r_pat_addr], r_mask[r_pat_addr]};
            default: w_rd[7:0] = r_leds;
        endcase
    end
endmodule
